// File: rtl/axis_frame_filter.sv
// axis_frame_filter: frame-aligned AXI-Stream pass/drop filter.
// The pass/drop decision is taken on the head beat of each frame and held
// until that frame's tlast. The datapath is zero latency with no storage.
// A one-shot drop_next request discards the next frame that starts.
// Optional statistics counters are enabled with AXIS_FRAME_FILTER_STAT_EN.
// When the macro is undefined, pass_cnt/drop_cnt read as zero.
module axis_frame_filter #(
  parameter int DSIZE = 32,
  parameter int USIZE = 1,
  parameter int KSIZE = DSIZE/8,
  parameter int CNT_W = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             button,
  input  logic             drop_next,
  input  logic [DSIZE-1:0] in_tdata,
  input  logic [KSIZE-1:0] in_tkeep,
  input  logic [USIZE-1:0] in_tuser,
  input  logic             in_tlast,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [DSIZE-1:0] out_tdata,
  output logic [KSIZE-1:0] out_tkeep,
  output logic [USIZE-1:0] out_tuser,
  output logic             out_tlast,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             frame_busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {S_HEAD = 2'd0, S_PASS = 2'd1, S_DROP = 2'd2} state_t;

  state_t state, state_nxt;
  logic   drop_pend;
  logic   decide_pass;
  logic   pass_path;
  logic   accept;
  logic   head_acc;

  // Payload is always wired through; only valid/ready are gated.
  assign out_tdata = in_tdata;
  assign out_tkeep = in_tkeep;
  assign out_tuser = in_tuser;
  assign out_tlast = in_tlast;

  // A pending or same-cycle drop request overrides the button.
  assign decide_pass = button & ~drop_pend & ~drop_next;
  assign accept      = in_tvalid & in_tready;
  assign head_acc    = (state == S_HEAD) & accept;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_HEAD;
    else          state <= state_nxt;
  end

  // Next state: head beat picks PASS/DROP, tlast returns to HEAD.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_HEAD:  if (!in_tlast) state_nxt = decide_pass ? S_PASS : S_DROP;
        default: if (in_tlast)  state_nxt = S_HEAD;
      endcase
    end
  end

  // Outputs: route valid/ready through the pass or drop path.
  always_comb begin
    pass_path = 1'b0;
    in_tready = out_tready;
    case (state)
      S_PASS: begin
        pass_path = 1'b1;
        in_tready = out_tready;
      end
      S_DROP: begin
        pass_path = 1'b0;
        in_tready = 1'b1;
      end
      default: begin
        // With no head beat present, ready simply follows downstream.
        pass_path = decide_pass;
        in_tready = (in_tvalid & ~decide_pass) ? 1'b1 : out_tready;
      end
    endcase
    out_tvalid = in_tvalid & pass_path;
    frame_busy = (state != S_HEAD);
  end

  // One-shot drop request: consumed by the next head beat that is dropped.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                    drop_pend <= 1'b0;
    else if (head_acc & ~decide_pass) drop_pend <= 1'b0;
    else if (drop_next)              drop_pend <= 1'b1;
  end

`ifdef AXIS_FRAME_FILTER_STAT_EN
  logic             frame_done;
  logic [CNT_W-1:0] pass_q, drop_q;

  assign frame_done = accept & in_tlast;

  // Saturating per-decision frame counters, bumped on each frame's tlast.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pass_q <= '0;
      drop_q <= '0;
    end else if (frame_done) begin
      if (pass_path  && pass_q != '1) pass_q <= pass_q + 1'b1;
      if (!pass_path && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign pass_cnt = pass_q;
  assign drop_cnt = drop_q;
`else
  assign pass_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_frame_filter.sv
// tb_axis_frame_filter: scoreboard bench for axis_frame_filter.
// A reference model predicts each beat's fate when it is driven; forwarded
// beats are queued and matched against the output as they leave the DUT.
module tb_axis_frame_filter;

`ifdef AXIS_FRAME_FILTER_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif
  localparam int CNT_W = 3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        button, drop_next;
  logic [31:0] in_tdata;
  logic [3:0]  in_tkeep;
  logic [0:0]  in_tuser;
  logic        in_tlast, in_tvalid, in_tready;
  logic [31:0] out_tdata;
  logic [3:0]  out_tkeep;
  logic [0:0]  out_tuser;
  logic        out_tlast, out_tvalid, out_tready;
  logic        frame_busy;
  logic [CNT_W-1:0] pass_cnt, drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [37:0] sb[$];

  // reference model
  int   m_state = 0;  // 0 head, 1 pass, 2 drop
  logic m_pend  = 1'b0;
  int   m_pc    = 0;
  int   m_dc    = 0;

  logic       tog_en = 1'b0;
  logic [3:0] pat    = 4'b1001;
  int         tidx   = 0;

  axis_frame_filter #(.DSIZE(32), .USIZE(1), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .button(button), .drop_next(drop_next),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tuser(in_tuser),
    .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tuser(out_tuser),
    .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .frame_busy(frame_busy), .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ecnt(input int c);
    int s;
    s = (c > 7) ? 7 : c;
    return STAT ? 64'(s) : 64'd0;
  endfunction

  // downstream ready: constant 1 or the 1,0,0,1 pattern
  always @(posedge aclk) begin
    #1;
    out_tready = tog_en ? pat[tidx] : 1'b1;
    tidx = (tidx + 1) % 4;
  end

  // output monitor: every transfer must match the scoreboard head
  always @(negedge aclk) begin
    if (aresetn && out_tvalid && out_tready) begin
      if (sb.size() == 0) chk("sb_unexpected", 64'(sb.size()), 64'd1);
      else chk("beat", 64'({out_tdata, out_tkeep, out_tuser, out_tlast}), 64'(sb.pop_front()));
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_busy"}, 64'(frame_busy), 64'(m_state != 0));
    chk({tag, "_pcnt"}, 64'(pass_cnt), ecnt(m_pc));
    chk({tag, "_dcnt"}, 64'(drop_cnt), ecnt(m_dc));
  endtask

  task automatic send(input int fid, input int b, input logic last);
    logic pp;
    logic done;
    int   n;
    in_tdata  = 32'((fid << 8) | b);
    in_tkeep  = 4'(fid + b);
    in_tuser  = 1'(b);
    in_tlast  = last;
    in_tvalid = 1'b1;
    pp = (m_state == 1) || (m_state == 0 && button && !m_pend && !drop_next);
    if (pp) sb.push_back({in_tdata, in_tkeep, in_tuser, in_tlast});
    done = 1'b0;
    n = 0;
    while (!done) begin
      @(negedge aclk);
      n++;
      if (pp) chk("rdy_mirror", 64'(in_tready), 64'(out_tready));
      else begin
        chk("drop_rdy", 64'(in_tready), 64'd1);
        chk("drop_vld", 64'(out_tvalid), 64'd0);
      end
      if (in_tready) done = 1'b1;
      else if (n >= 100) begin
        chk("accept_timeout", 64'(n), 64'd0);
        done = 1'b1;
      end
    end
    if (m_state == 0) begin
      if (!pp) m_pend = 1'b0;
      if (last) begin
        if (pp) m_pc++; else m_dc++;
      end else m_state = pp ? 1 : 2;
    end else begin
      if (drop_next) m_pend = 1'b1;
      if (last) begin
        if (m_state == 1) m_pc++; else m_dc++;
        m_state = 0;
      end
    end
    @(posedge aclk);
    #1;
    in_tvalid = 1'b0;
    drop_next = 1'b0;
    chk("busy", 64'(frame_busy), 64'(m_state != 0));
  endtask

  task automatic frame(input int fid, input int len);
    for (int b = 1; b <= len; b++) send(fid, b, b == len);
  endtask

  // idle-cycle drop request
  task automatic pulse_drop();
    drop_next = 1'b1;
    @(posedge aclk);
    #1;
    drop_next = 1'b0;
    m_pend = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0; button = 1'b0; drop_next = 1'b0;
    in_tdata = '0; in_tkeep = '0; in_tuser = '0; in_tlast = 1'b0; in_tvalid = 1'b0;
    out_tready = 1'b1;
    #1;
    check_state("reset");
    chk("reset_vld", 64'(out_tvalid), 64'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    // three passing 4-beat frames
    button = 1'b1;
    for (int f = 1; f <= 3; f++) frame(f, 4);
    check_state("pass3");

    // two dropped 5-beat frames
    button = 1'b0;
    for (int f = 4; f <= 5; f++) frame(f, 5);
    check_state("drop2");

    // button falls at beat 2: frame still forwarded, next one dropped
    button = 1'b1;
    send(6, 1, 1'b0);
    button = 1'b0;
    for (int b = 2; b <= 6; b++) send(6, b, b == 6);
    frame(7, 3);
    check_state("btn_mid");

    // two drop_next pulses inside A collapse to one dropped frame (B)
    button = 1'b1;
    send(8, 1, 1'b0);
    send(8, 2, 1'b0);
    pulse_drop();
    pulse_drop();
    send(8, 3, 1'b0);
    send(8, 4, 1'b1);
    frame(9, 3);
    frame(10, 3);
    check_state("drop_next");

    // drop_next on the head beat itself drops that frame, nothing pending
    drop_next = 1'b1;
    frame(11, 2);
    frame(12, 2);
    check_state("drop_head");

    // downstream backpressure 1,0,0,1
    tog_en = 1'b1;
    frame(13, 6);
    tog_en = 1'b0;
    // single-beat frame
    frame(14, 1);
    check_state("single");

    // reset in the middle of a passing 8-beat frame
    send(15, 1, 1'b0);
    send(15, 2, 1'b0);
    in_tdata = 32'h0f03; in_tlast = 1'b0; in_tvalid = 1'b1;
    #1 aresetn = 1'b0;
    m_state = 0; m_pend = 1'b0; m_pc = 0; m_dc = 0;
    #1;
    check_state("mid_reset");
    in_tvalid = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    button = 1'b0;
    for (int b = 4; b <= 8; b++) send(15, b, b == 8);
    check_state("post_reset");

    repeat (3) @(posedge aclk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_frame_filter.md
Name: axis_frame_filter

Overview:
- Frame-aligned successor to the beat-level AXI-Stream filter. Passes or discards whole frames, never partial ones.
- The pass/filter decision is sampled on the first beat of each frame and held until that frame's tlast.
- Adds a one-shot "drop next frame" request, parametrised data/user widths, and per-decision statistics counters.
- Sits inline on any AXI-Stream path, between a producer and a downstream valve or FIFO.

Parameters:
- DSIZE, 32, tdata width in bits (multiple of 8)
- USIZE, 1, tuser width in bits
- KSIZE, DSIZE/8, tkeep width
- CNT_W, 32, width of statistics counters

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- button  in  1  level: 1 pass frames, 0 filter frames; sampled only at frame start
- drop_next  in  1  single-cycle pulse: discard the next frame that starts, regardless of button
- in_tdata  in  DSIZE  upstream data
- in_tkeep  in  KSIZE  upstream keep
- in_tuser  in  USIZE  upstream user
- in_tlast  in  1  upstream last
- in_tvalid  in  1  upstream valid
- in_tready  out  1  upstream ready
- out_tdata  out  DSIZE  downstream data
- out_tkeep  out  KSIZE  downstream keep
- out_tuser  out  USIZE  downstream user
- out_tlast  out  1  downstream last
- out_tvalid  out  1  downstream valid
- out_tready  in  1  downstream ready
- frame_busy  out  1  high while in PASS or DROP
- pass_cnt  out  CNT_W  frames forwarded, saturating
- drop_cnt  out  CNT_W  frames discarded, saturating

Behaviour:
- Clock and reset: single clock aclk; aresetn is asynchronous, active-low. Reset state: FSM=HEAD, drop_pend=0, pass_cnt=0, drop_cnt=0, frame_busy=0.
- FSM states:
  - HEAD: between frames.
  - PASS: forwarding the body of a frame.
  - DROP: discarding the body of a frame.
- Head decision: made combinationally on the first beat in HEAD. decide_pass = button & ~drop_pend & ~drop_next.
- Datapath, zero latency, no storage:
  - Pass path (HEAD with decide_pass, or PASS): out_* = in_*, out_tvalid = in_tvalid, in_tready = out_tready.
  - Drop path (HEAD with ~decide_pass, or DROP): out_tvalid = 0, in_tready = 1.
  - In HEAD with in_tvalid=0: out_tvalid = 0, in_tready = out_tready.
- Transitions, evaluated on each accepted beat (in_tvalid & in_tready):
  - HEAD, tlast=0: go to PASS or DROP according to decide_pass.
  - HEAD, tlast=1: single-beat frame; stay in HEAD; counters update.
  - PASS or DROP, tlast=1: return to HEAD; counters update.
- Counters: pass_cnt increments once per completed forwarded frame; drop_cnt once per completed dropped frame. Both saturate at all-ones and do not wrap.
- drop_pend:
  - Set by a drop_next pulse arriving while not at an accepted head beat.
  - Cleared when a frame's head beat is accepted with the drop decision.
  - drop_next on the same cycle as an accepted head beat drops that frame and leaves drop_pend=0.
  - Multiple pulses before a head beat collapse into one dropped frame.
- button toggling mid-frame has no effect until the next head beat.
- Backpressure: in PASS with out_tready=0, in_tready=0 and the beat is held. AXI rule: in_* must stay stable while valid and not ready.
- frame_busy = (state != HEAD).
- Reset asserted mid-frame: FSM returns to HEAD immediately. The remainder of the interrupted frame is then treated as a new frame and decided on its next beat. Upstream is responsible for flushing across reset.

Optional Feature:
- Macro AXIS_FRAME_FILTER_STAT_EN.
- Defined: pass_cnt and drop_cnt behave as above.
- Undefined: both counters are tied to 0 and no counter flops are synthesised. FSM and datapath are unchanged.

Test Plan:
- button=1, three 4-beat frames, out_tready=1 -> all 12 beats appear on out unchanged with tlast on beats 4/8/12; pass_cnt=3, drop_cnt=0.
- button=0, two 5-beat frames -> out_tvalid stays 0, in_tready=1 throughout; drop_cnt=2.
- button=1 at frame head, driven 0 at beat 2 of a 6-beat frame, second frame follows -> first frame fully forwarded (6 beats), second dropped; pass_cnt=1, drop_cnt=1.
- button=1, drop_next pulsed twice mid-frame A, then frames B and C -> A forwarded, B dropped, C forwarded; drop_cnt=1.
- Pass frame with out_tready toggling 1,0,0,1 per cycle -> in_tready mirrors out_tready, no beat lost or duplicated; single-beat frame (tlast on head) -> FSM stays HEAD, pass_cnt +1.
- aresetn pulsed low during beat 3 of a passing 8-beat frame -> outputs and counters at reset values within the reset cycle; next beat treated as a head beat and decided fresh.
